// File: rtl/simd_pkg.sv
// Shared constants, the write-back entry type and a lane popcount helper
// for the SIMD result write-back slice.
package simd_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 32;
  localparam int VEC_W      = LANES * LANE_W;
  localparam int DEPTH      = 4;
  localparam int REG_ADDR_W = 4;
  localparam int STAT_W     = 16;

  // One queued register-file write: destination, per-lane enables, data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [LANES-1:0]      we;
    logic [VEC_W-1:0]      data;
  } wb_entry_t;

  // Number of lanes that produced no result.
  function automatic logic [STAT_W-1:0] nop_popcount(input logic [LANES-1:0] flags);
    logic [STAT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + STAT_W'(flags[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/simd_wb_fifo.sv
// Generic FIFO of wb_entry_t with occupancy count and synchronous flush.
// Flush wins over push and pop; the head reads as all-zero when empty.
module simd_wb_fifo
  import simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output wb_entry_t                  head,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];

  logic empty;
  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
      if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  // NOTE: storage is not reset; the zero-count gate on head hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/simd_result_writeback.sv
// SIMD result write-back: turns ALU results plus per-lane nop flags into
// masked vector register file writes, queued in order through a small FIFO.
// Entries with no enabled lane complete the handshake but are not stored.
// Optional feature macro: SIMD_WB_STATS_EN enables the saturating
// nop_lane_count statistic; without it the output is tied to zero.
module simd_result_writeback
  import simd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VEC_W-1:0]      in_result,
  input  logic [LANES-1:0]      in_nop_flags,
  input  logic                  in_write,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  flush,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [VEC_W-1:0]      wb_data,
  output logic [LANES-1:0]      wb_lane_we,
  output logic                  busy,
  output logic [STAT_W-1:0]     nop_lane_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             full;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic [LANES-1:0] lane_mask;
  logic             store;
  wb_entry_t        new_entry;
  wb_entry_t        head;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign lane_mask = in_write ? ~in_nop_flags : '0;
  assign store     = accept && (lane_mask != '0);

  assign new_entry.dest = in_dest;
  assign new_entry.we   = lane_mask;
  assign new_entry.data = in_result;

  simd_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (store),
    .push_entry (new_entry),
    .pop        (wb_valid && wb_ready),
    .flush      (flush),
    .head       (head),
    .full       (full),
    .count      (count)
  );

  assign wb_valid   = (count != '0);
  assign busy       = (count != '0);
  assign wb_addr    = head.dest;
  assign wb_data    = head.data;
  assign wb_lane_we = head.we;

`ifdef SIMD_WB_STATS_EN
  logic [STAT_W-1:0] nop_cnt_q, nop_cnt_d;
  logic [STAT_W:0]   nop_sum;

  // Saturating nop-lane tally over accepted writing instructions; flush does not touch it.
  always_comb begin
    nop_cnt_d = nop_cnt_q;
    nop_sum   = {1'b0, nop_cnt_q} + {1'b0, nop_popcount(in_nop_flags)};
    if (accept && in_write) begin
      nop_cnt_d = nop_sum[STAT_W] ? {STAT_W{1'b1}} : nop_sum[STAT_W-1:0];
    end
  end

  // Statistic register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nop_cnt_q <= '0;
    else        nop_cnt_q <= nop_cnt_d;
  end

  assign nop_lane_count = nop_cnt_q;
`else
  assign nop_lane_count = '0;
`endif

endmodule
